packet_gen: RTL
===============

Name: packet_gen

Overview:
- Per-channel AXI4-Stream packet generator. One instance feeds each Ethernet channel's TX path.
- Its `busy` output drives the `chN_busy` inputs of the status block. That block synchronises `busy` and reports it over AXI4-Lite and LEDs.
- Software launches a burst of fixed-length packets with a `start` pulse. The block emits them with a programmable inter-packet gap.

Parameters:
- DW, 64, stream data width in bits; must be a multiple of 64 and at least 64.
- LEN_W, 16, width of the packet-length field (beats per packet).
- CNT_W, 32, width of the packet-count and packets-sent counters.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; launches a burst
- abort  in  1  single-cycle pulse; ends the burst at the next packet boundary
- cfg_pkt_len  in  LEN_W  beats per packet, sampled on start
- cfg_pkt_count  in  CNT_W  packets per burst, sampled on start
- cfg_gap  in  8  idle cycles between packets, sampled on start
- busy  out  1  high while a burst is in progress
- pkts_sent  out  CNT_W  packets completed in the current or last burst
- axis_tdata  out  DW  stream data
- axis_tvalid  out  1  stream valid
- axis_tlast  out  1  last beat of packet
- axis_tready  in  1  downstream ready

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - busy, axis_tvalid, axis_tlast = 0.
  - axis_tdata = 0, pkts_sent = 0, all internal counters = 0.
  - Reset asserted mid-burst drops tvalid immediately; the partial packet is abandoned.
- States: IDLE, SEND, GAP.
- IDLE:
  - On start with cfg_pkt_len != 0 and cfg_pkt_count != 0:
    - latch the config;
    - clear pkts_sent, pkt_idx and beat_idx;
    - next cycle: busy = 1, axis_tvalid = 1, state = SEND.
  - This gives a latency of 1 cycle from start to the first tvalid.
  - start with a zero length or zero count is ignored: busy stays 0 and pkts_sent is unchanged.
- SEND:
  - Beat data is the 64-bit word {pkt_idx[31:0], beat_idx[31:0]}, replicated DW/64 times. pkt_idx is zero-extended or truncated to 32 bits.
  - axis_tlast = 1 exactly when beat_idx == len-1.
  - AXI-Stream rules apply: once tvalid is high, tdata, tlast and tvalid hold stable until tready is sampled high. tvalid never depends on tready.
  - On a handshake that is not the last beat: beat_idx increments.
  - On a handshake of the last beat (tlast):
    - pkts_sent and pkt_idx increment; beat_idx clears.
    - If pkts_sent+1 == count, or an abort is pending: next state IDLE; busy and tvalid drop the next cycle.
    - Otherwise, if gap == 0: stay in SEND, back-to-back, tvalid stays high.
    - Otherwise: go to GAP with tvalid low and gap_cnt = gap.
- GAP:
  - gap_cnt decrements each cycle.
  - When gap_cnt reaches 1, the next cycle is SEND with tvalid = 1.
  - This gives exactly cfg_gap idle cycles between the tlast handshake and the next valid beat.
- abort:
  - Sets a sticky abort_pending flag when seen in SEND or GAP; ignored in IDLE.
  - In SEND: the current packet completes normally, then the block returns to IDLE.
  - In GAP: the block goes to IDLE on the next cycle without sending another packet.
  - abort_pending clears on entry to IDLE.
- start while busy is ignored, including start arriving in the same cycle as the final tlast handshake.
- pkts_sent holds its value in IDLE until the next accepted start.
- Counters wrap modulo 2^CNT_W. No overflow flag.
- cfg_* changes during a burst have no effect.

Optional Feature:
- Macro: PACKET_GEN_HEADER_EN.
- Defined: beat 0 of every packet is a header whose low 64 bits are {16'hA5A5, len[15:0], pkt_idx[31:0]}; upper bits are 0. Beats 1..len-1 use the normal pattern. Length includes the header, so len == 1 sends header-only packets.
- Undefined: every beat uses the normal pattern. No header logic is synthesised.

Test Plan:
- len=4, count=3, gap=0, tready=1 → 12 consecutive valid beats; tlast on beats 3, 7 and 11; pkts_sent=3; busy high for exactly 12 cycles, starting 1 cycle after start.
- len=2, count=2, gap=5, tready=1 → exactly 5 tvalid-low cycles between the first tlast handshake and the second packet's beat 0.
- len=8, count=1, tready toggling with a random 50% pattern → tdata and tlast stable while tvalid && !tready; beat 5 data = 0x00000000_00000005.
- count=10, abort pulsed during beat 2 of packet 3 → packet 3 completes; pkts_sent=4; busy drops 1 cycle after its tlast.
- resetn low during beat 1 of a burst → tvalid, busy and pkts_sent are 0 in the same cycle. A new start after release sends from pkt_idx 0.
- start with len=0, and start while busy → no tvalid and busy unchanged; with PACKET_GEN_HEADER_EN defined, len=3 gives beat 0 = 0xA5A50003_00000000.

Source files
------------

// File: rtl/packet_gen.sv
// packet_gen: per-channel AXI4-Stream packet generator.
// A start pulse launches a burst of fixed-length packets with a programmable
// idle gap between them. busy, tvalid and tlast are decoded from the state
// register, so an asynchronous reset drops them in the same cycle.
// Optional build macro: PACKET_GEN_HEADER_EN makes beat 0 of every packet a
// header word {16'hA5A5, len[15:0], pkt_idx[31:0]} (upper data bits zero).
module packet_gen #(
    parameter int DW    = 64,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_pkt_len,
    input  logic [CNT_W-1:0] cfg_pkt_count,
    input  logic [7:0]       cfg_gap,
    output logic             busy,
    output logic [CNT_W-1:0] pkts_sent,
    output logic [DW-1:0]    axis_tdata,
    output logic             axis_tvalid,
    output logic             axis_tlast,
    input  logic             axis_tready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       gap_r;
    logic [7:0]       gap_cnt;
    logic [CNT_W-1:0] pkt_idx;
    logic [LEN_W-1:0] beat_idx;
    logic             abort_pending;

    logic             handshake;
    logic             last_beat;
    logic [CNT_W-1:0] sent_next;
    logic [63:0]      beat_word;

    assign busy        = (state != ST_IDLE);
    assign axis_tvalid = (state == ST_SEND);
    assign last_beat   = (beat_idx == len_r - LEN_W'(1));
    assign axis_tlast  = axis_tvalid && last_beat;
    assign handshake   = axis_tvalid && axis_tready;
    assign sent_next   = pkts_sent + CNT_W'(1);
    assign beat_word   = {32'(pkt_idx), 32'(beat_idx)};

    // Beat data is a pure function of the held indices, so it stays stable while stalled
    always_comb begin
        axis_tdata = '0;
        if (axis_tvalid) begin
            axis_tdata = {(DW/64){beat_word}};
`ifdef PACKET_GEN_HEADER_EN
            if (beat_idx == '0) begin
                axis_tdata       = '0;
                axis_tdata[63:0] = {16'hA5A5, 16'(len_r), 32'(pkt_idx)};
            end
`endif
        end
    end

    // Burst sequencer: IDLE -> SEND (-> GAP -> SEND)* -> IDLE, config latched on start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            len_r         <= '0;
            count_r       <= '0;
            gap_r         <= '0;
            gap_cnt       <= '0;
            pkt_idx       <= '0;
            beat_idx      <= '0;
            pkts_sent     <= '0;
            abort_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    abort_pending <= 1'b0;
                    if (start && (cfg_pkt_len != '0) && (cfg_pkt_count != '0)) begin
                        len_r     <= cfg_pkt_len;
                        count_r   <= cfg_pkt_count;
                        gap_r     <= cfg_gap;
                        pkts_sent <= '0;
                        pkt_idx   <= '0;
                        beat_idx  <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (handshake) begin
                        if (last_beat) begin
                            pkts_sent <= sent_next;
                            pkt_idx   <= pkt_idx + CNT_W'(1);
                            beat_idx  <= '0;
                            if ((sent_next == count_r) || abort_pending || abort) begin
                                state         <= ST_IDLE;
                                abort_pending <= 1'b0;
                            end else if (gap_r != 8'd0) begin
                                state   <= ST_GAP;
                                gap_cnt <= gap_r;
                            end
                        end else begin
                            beat_idx <= beat_idx + LEN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (abort_pending || abort) begin
                        state         <= ST_IDLE;
                        abort_pending <= 1'b0;
                    end else if (gap_cnt == 8'd1) begin
                        state <= ST_SEND;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
